coin_pulse_conditioner: RTL and testbench

Front-end stage of the vending controller: it turns the three raw, asynchronous, bouncing coin-sensor lines (1, 2 and 5 yuan) into clean single-cycle coin pulses. The pulses are mutually exclusive and are wired straight to the controller's `i_1yuan` / `i_2yuan` / `i_5yuan` inputs. Each line is synchronised and debounced. Each rising edge is queued in a one-deep pending slot per channel. Pending coins are serialised one per clock by fixed priority, and emission can be stalled by downstream back-pressure.

---
 rtl/coin_pulse_conditioner.sv | 175 +++++++++++++++++
 tb/tb_coin_pulse_conditioner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_pulse_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// coin_pulse_conditioner
//
// Front end of the vending controller. Converts three raw, asynchronous,
// bouncing coin-sensor lines (1, 2 and 5 yuan) into clean, mutually exclusive,
// single-cycle coin pulses.
//
// Per channel:
//   raw -> SYNC_STAGES flip-flop synchroniser -> debounce counter -> rising
//   edge of the debounced level sets a one-deep pending slot.
// Shared:
//   fixed-priority arbiter (1 > 2 > 5) drains one pending coin per clock
//   unless i_hold stalls it.
//
// Handshake: there is no valid/ready pair here. A coin is "presented" by a
// one-cycle high on exactly one of o_1yuan / o_2yuan / o_5yuan. The consumer
// stalls emission by driving i_hold high; i_hold is sampled on the same edge
// that would register a pulse, and a stalled coin stays in its pending slot.
//
// Ports:
//   i_clk                 system clock
//   i_rst                 asynchronous, active-high reset
//   i_coin_1/2/5          raw coin-sensor levels (asynchronous, may bounce)
//   i_hold                downstream stall, no pulse is registered while high
//   o_1yuan/2yuan/5yuan   registered single-cycle coin pulses, one-hot or zero
//   o_pending[2:0]        registered pending slots {5, 2, 1 yuan}
//   o_overrun             single-cycle pulse when a coin lands on a full slot
// -----------------------------------------------------------------------------
module coin_pulse_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_coin_1,
   input  logic       i_coin_2,
   input  logic       i_coin_5,
   input  logic       i_hold,
   output logic       o_1yuan,
   output logic       o_2yuan,
   output logic       o_5yuan,
   output logic [2:0] o_pending,
   output logic       o_overrun
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   // Channel index: 0 = 1 yuan, 1 = 2 yuan, 2 = 5 yuan.
   logic [2:0] coin_raw;
   assign coin_raw = {i_coin_5, i_coin_2, i_coin_1};

   // ---------------------------------------------------------------------------
   // Synchroniser chains. Stage 0 samples the raw line; the top stage is the
   // synchronised level seen by the debouncer.
   // ---------------------------------------------------------------------------
   logic [2:0][SYNC_STAGES-1:0] sync_q;
   logic [2:0][SYNC_STAGES-1:0] sync_d;
   logic [2:0]                  sync_lvl;

   always_comb begin
      for (int c = 0; c < 3; c++) begin
         sync_d[c]   = {sync_q[c][SYNC_STAGES-2:0], coin_raw[c]};
         sync_lvl[c] = sync_q[c][SYNC_STAGES-1];
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Debouncers. The counter runs only while the synchronised level disagrees
   // with the debounced level; any agreement restarts it, so only an unbroken
   // run of DEBOUNCE_CYCLES disagreeing clocks flips the debounced level.
   // ---------------------------------------------------------------------------
   logic [2:0]         deb_q;
   logic [2:0]         deb_d;
   logic [2:0][CW-1:0] cnt_q;
   logic [2:0][CW-1:0] cnt_d;
   logic [2:0]         coin_evt;

   always_comb begin
      deb_d = deb_q;
      cnt_d = cnt_q;
      for (int c = 0; c < 3; c++) begin
         if (sync_lvl[c] == deb_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CNT_MAX) begin
            deb_d[c] = sync_lvl[c];
            cnt_d[c] = '0;
         end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
         end
      end
   end

   // A coin event is the debounced level rising on this edge. Using deb_d lets
   // the pending slot be set on the very edge the debounced level flips.
   assign coin_evt = deb_d & ~deb_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         deb_q <= '0;
         cnt_q <= '0;
      end else begin
         deb_q <= deb_d;
         cnt_q <= cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Pending slots and fixed-priority arbiter.
   // ---------------------------------------------------------------------------
   logic [2:0] pend_q;
   logic [2:0] pend_d;
   logic [2:0] grant;
   logic [2:0] pulse_q;
   logic       ovr_q;
   logic       ovr_d;

   always_comb begin
      grant = 3'b000;
      if (!i_hold) begin
         if (pend_q[0]) begin
            grant = 3'b001;
         end else if (pend_q[1]) begin
            grant = 3'b010;
         end else if (pend_q[2]) begin
            grant = 3'b100;
         end
      end
   end

   // A new event on the slot being granted refills it: the old coin leaves,
   // the new one stays, and that is not an overrun. Only an event on a slot
   // that stays full loses a coin.
   always_comb begin
      pend_d = (pend_q & ~grant) | coin_evt;
      ovr_d  = |(coin_evt & pend_q & ~grant);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pend_q  <= '0;
         pulse_q <= '0;
         ovr_q   <= 1'b0;
      end else begin
         pend_q  <= pend_d;
         pulse_q <= grant;
         ovr_q   <= ovr_d;
      end
   end

   assign o_1yuan   = pulse_q[0];
   assign o_2yuan   = pulse_q[1];
   assign o_5yuan   = pulse_q[2];
   assign o_pending = pend_q;
   assign o_overrun = ovr_q;

   // ---------------------------------------------------------------------------
   // Invariants of the output contract.
   // ---------------------------------------------------------------------------
   a_pulse_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
      $onehot0(pulse_q));

   a_hold_blocks: assert property (@(posedge i_clk) disable iff (i_rst)
      i_hold |=> (pulse_q == 3'b000));

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_coin_pulse_conditioner
//
// Each phase fills a per-edge stimulus table (raw levels and hold), computes
// the expected outputs from the debounce/arbitration rules, queues every edge
// on which some output is non-zero, then drives the table. A monitor pops and
// compares whenever the DUT shows any activity. Phases end with a reset.
// -----------------------------------------------------------------------------
module tb_coin_pulse_conditioner;

   localparam int S    = 2;
   localparam int D    = 16;
   localparam int MAXN = 512;
   localparam int W    = 39;   // {edge[31:0], pulse{5,2,1}, overrun, pending[2:0]}

   logic       i_clk;
   logic       i_rst;
   logic       i_coin_1, i_coin_2, i_coin_5;
   logic       i_hold;
   logic       o_1yuan, o_2yuan, o_5yuan;
   logic [2:0] o_pending;
   logic       o_overrun;

   coin_pulse_conditioner #(
      .SYNC_STAGES    (S),
      .DEBOUNCE_CYCLES(D)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_coin_1 (i_coin_1),
      .i_coin_2 (i_coin_2),
      .i_coin_5 (i_coin_5),
      .i_hold   (i_hold),
      .o_1yuan  (o_1yuan),
      .o_2yuan  (o_2yuan),
      .o_5yuan  (o_5yuan),
      .o_pending(o_pending),
      .o_overrun(o_overrun)
   );

   // ---------------------------------------------------------------- clock/reset
   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Edges since reset release; edge 1 is the first edge after release.
   int edge_no;
   always @(posedge i_clk or posedge i_rst) begin
      if (i_rst) edge_no <= 0;
      else       edge_no <= edge_no + 1;
   end

   // ---------------------------------------------------------------- stimulus
   logic [2:0] raw_a  [MAXN+2];   // raw_a[t][c]: level sampled by edge t
   logic       hold_a [MAXN+2];

   logic [W-1:0] exp_q[$];
   int n_vec = 0;
   int n_err = 0;

   task automatic clear_stim();
      for (int t = 0; t < MAXN + 2; t++) begin
         raw_a[t]  = 3'b000;
         hold_a[t] = 1'b0;
      end
   endtask

   task automatic set_raw(input int c, input int a, input int b, input logic v);
      for (int t = a; t <= b && t <= MAXN; t++) raw_a[t][c] = v;
   endtask

   task automatic set_hold(input int a, input int b, input logic v);
      for (int t = a; t <= b && t <= MAXN; t++) hold_a[t] = v;
   endtask

   task automatic drive(input int t);
      i_coin_1 = raw_a[t][0];
      i_coin_2 = raw_a[t][1];
      i_coin_5 = raw_a[t][2];
      i_hold   = hold_a[t];
   endtask

   // ---------------------------------------------------------------- reference
   // Debounce view: split each raw line into constant runs. A run whose level
   // differs from the current debounced level and lasts at least D clocks
   // flips the level on edge (run start + S - 1 + D). Rising flips are coins.
   // Arbiter view: pending set of coins, lowest-value coin leaves first.
   task automatic model_phase(input int n);
      logic [2:0] ev [MAXN+2];
      logic [2:0] pend, grant, newp;
      logic       ovr, deb, lvl;
      int         t, s, fe;
      for (int k = 0; k < MAXN + 2; k++) ev[k] = 3'b000;
      for (int c = 0; c < 3; c++) begin
         deb = 1'b0;
         t   = 1;
         while (t <= n) begin
            lvl = raw_a[t][c];
            s   = t;
            while (t <= n && raw_a[t][c] == lvl) t++;
            if (lvl != deb && (t - s) >= D) begin
               fe = s + S - 1 + D;
               if (fe <= n) begin
                  deb = lvl;
                  if (lvl) ev[fe][c] = 1'b1;
               end
            end
         end
      end
      pend = 3'b000;
      for (int e = 1; e <= n; e++) begin
         grant = 3'b000;
         if (!hold_a[e]) begin
            for (int c = 2; c >= 0; c--) if (pend[c]) grant = 3'b001 << c;
         end
         newp = (pend & ~grant) | ev[e];
         ovr  = |(ev[e] & pend & ~grant);
         if (grant != 3'b000 || ovr || newp != 3'b000)
            exp_q.push_back({32'(e), grant, ovr, newp});
         pend = newp;
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic [W-1:0] mon_act, mon_exp;
   always @(negedge i_clk) begin
      if (!i_rst && (o_1yuan || o_2yuan || o_5yuan || o_overrun || o_pending != 3'b000)) begin
         mon_act = {32'(edge_no), o_5yuan, o_2yuan, o_1yuan, o_overrun, o_pending};
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL monitor_unexpected: edge %0d pulse521=%b ovr=%b pend=%b, required no activity",
                     edge_no, mon_act[6:4], mon_act[3], mon_act[2:0]);
         end else begin
            mon_exp = exp_q.pop_front();
            if (mon_act !== mon_exp) begin
               n_err++;
               $display("FAIL monitor: got edge %0d pulse521=%b ovr=%b pend=%b, required edge %0d pulse521=%b ovr=%b pend=%b",
                        mon_act[38:7], mon_act[6:4], mon_act[3], mon_act[2:0],
                        mon_exp[38:7], mon_exp[6:4], mon_exp[3], mon_exp[2:0]);
            end
         end
      end
   end

   // ---------------------------------------------------------------- phases
   task automatic check_zero(input string name);
      logic [6:0] v;
      v = {o_5yuan, o_2yuan, o_1yuan, o_overrun, o_pending};
      n_vec++;
      if (v !== 7'b0) begin
         n_err++;
         $display("FAIL %s: outputs {pulse521,ovr,pend}=%b, required 0000000", name, v);
      end
   endtask

   // Called with reset asserted; releases it with stim[1] in place.
   task automatic start_phase(input int n);
      model_phase(n);
      @(negedge i_clk);
      drive(1);
      i_rst = 1'b0;
      for (int t = 2; t <= n; t++) begin
         @(negedge i_clk);
         drive(t);
      end
   endtask

   // Lets the monitor see edge n, checks nothing is outstanding, then resets.
   task automatic end_phase(input string name);
      @(negedge i_clk);
      #2;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: %0d expected events not seen (first at edge %0d), required 0",
                  name, exp_q.size(), exp_q[0][38:7]);
      end
      exp_q.delete();
      i_rst = 1'b1;
      #1;
      check_zero({name, "_reset"});
   endtask

   initial begin
      int t, len;
      logic lvl;
      i_rst = 1'b1;
      i_coin_1 = 1'b0; i_coin_2 = 1'b0; i_coin_5 = 1'b0; i_hold = 1'b0;
      repeat (3) @(negedge i_clk);
      check_zero("reset_state");

      // Clean 2-yuan coin: pending set at edge 18, pulse after edge 19.
      clear_stim();
      set_raw(1, 1, 40, 1'b1);
      start_phase(60);
      end_phase("clean_coin");

      // Bounce every 3 cycles, a 15-cycle pulse (rejected), a 16-cycle pulse.
      clear_stim();
      for (int k = 1; k <= 60; k++) raw_a[k][2] = (((k - 1) / 3) % 2 == 0);
      set_raw(2, 81, 95, 1'b1);
      set_raw(2, 131, 146, 1'b1);
      start_phase(200);
      end_phase("bounce");

      // All three at once: drain 1, 2, 5 after edges 19, 20, 21.
      clear_stim();
      for (int c = 0; c < 3; c++) set_raw(c, 1, 40, 1'b1);
      start_phase(60);
      end_phase("simultaneous");

      // Held: two 1-yuan coins, second overruns, one pulse after hold drops.
      clear_stim();
      set_hold(1, 100, 1'b1);
      set_raw(0, 1, 20, 1'b1);
      set_raw(0, 41, 70, 1'b1);
      start_phase(140);
      end_phase("hold_overrun");

      // Reset with pending 101 and a 2-yuan debounce half done.
      clear_stim();
      set_hold(1, 30, 1'b1);
      set_raw(0, 1, 30, 1'b1);
      set_raw(2, 1, 30, 1'b1);
      set_raw(1, 20, 30, 1'b1);
      start_phase(30);
      end_phase("mid_reset");

      // 1-yuan line stayed high through reset: one coin, pulse after edge 19.
      clear_stim();
      set_raw(0, 1, 40, 1'b1);
      start_phase(60);
      end_phase("held_through_reset");

      // Coins 2, 2, 5 spaced 40 cycles apart: three pulses.
      clear_stim();
      set_raw(1, 1, 20, 1'b1);
      set_raw(1, 41, 60, 1'b1);
      set_raw(2, 81, 100, 1'b1);
      start_phase(140);
      end_phase("sequence_225");

      // Random runs on every line and on hold.
      for (int r = 0; r < 4; r++) begin
         clear_stim();
         for (int c = 0; c < 3; c++) begin
            t   = 1;
            lvl = 1'(($urandom() >> 3) & 1);
            while (t <= 400) begin
               len = $urandom_range(1, 45);
               set_raw(c, t, t + len - 1, lvl);
               t   = t + len;
               lvl = ~lvl;
            end
         end
         t = 1;
         while (t <= 400) begin
            len = $urandom_range(1, 30);
            set_hold(t, t + len - 1, ($urandom_range(0, 2) == 0));
            t = t + len;
         end
         start_phase(400);
         end_phase("random");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
